// File: rtl/rr_arbiter8_pkg.sv
// Shared encodings and sizing for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8_decoder3.sv
// 3-to-8 one-hot decoder; a is the MSB of the select.
module rr_arbiter8_decoder3 (
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [7:0] x
);

    always_comb begin
        x = 8'b0000_0001 << {a, b, c};
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a per-grant hold limit.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic [2:0] GNT_IDX,
    output logic       GNT_VALID,
    output logic       TIMEOUT
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);
    localparam logic             HAS_LIMIT = (MAX_HOLD != 0);

    state_t             state, stateNxt;
    logic [IDX_W-1:0]   gntIdx, idxNxt;
    logic [IDX_W-1:0]   ptr, ptrNxt;
    logic [CNT_W-1:0]   cnt, cntNxt;
    logic               timeoutQ, timeoutNxt;
    logic [IDX_W:0]     win;
    logic               reqCur;
    logic               atLimit;
    logic               rel;
    logic [7:0]         decX;

    // Lowest k wins; k = N_REQ maps back onto ptr itself (lowest priority).
    function automatic logic [IDX_W:0] pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] p
    );
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = p + IDX_W'(k);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            gntIdx   <= '0;
            ptr      <= 3'd7;
            cnt      <= '0;
            timeoutQ <= 1'b0;
        end else begin
            state    <= stateNxt;
            gntIdx   <= idxNxt;
            ptr      <= ptrNxt;
            cnt      <= cntNxt;
            timeoutQ <= timeoutNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        idxNxt     = gntIdx;
        ptrNxt     = ptr;
        cntNxt     = cnt;
        timeoutNxt = 1'b0;
        win        = pick(REQ, ptr);
        reqCur     = REQ[gntIdx];
        atLimit    = HAS_LIMIT && (cnt == LIMIT);
        rel        = !reqCur || atLimit;
        unique case (state)
            ST_IDLE: begin
                if (EN && win[IDX_W]) begin
                    stateNxt = ST_GRANT;
                    idxNxt   = win[IDX_W-1:0];
                    ptrNxt   = win[IDX_W-1:0];
                    cntNxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!rel) begin
                    if (cnt != '1) cntNxt = cnt + 1'b1;
                end else begin
                    timeoutNxt = atLimit && reqCur;
                    cntNxt     = '0;
                    if (EN && win[IDX_W]) begin
                        idxNxt = win[IDX_W-1:0];
                        ptrNxt = win[IDX_W-1:0];
                    end else begin
                        stateNxt = ST_IDLE;
                    end
                end
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    rr_arbiter8_decoder3 uDec (
        .a (gntIdx[2]),
        .b (gntIdx[1]),
        .c (gntIdx[0]),
        .x (decX)
    );

    assign GNT_VALID = (state == ST_GRANT);
    assign GNT       = decX & {N_REQ{GNT_VALID}};
    assign GNT_IDX   = gntIdx;
    assign TIMEOUT   = timeoutQ;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed and random checks of rr_arbiter8 against a cycle-count model.
module tb_rr_arbiter8;

    localparam int MAXH = 8;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic [7:0] REQ = 8'h00;
    logic [7:0] GNT;
    logic [2:0] GNT_IDX;
    logic       GNT_VALID;
    logic       TIMEOUT;

    int vectors = 0;
    int miscompares = 0;

    // Model: grant owner, last winner, cycles already shown, timeout flag.
    int mValid, mIdx, mPtr, mHeld, mTo;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .EN        (EN),
        .REQ       (REQ),
        .GNT       (GNT),
        .GNT_IDX   (GNT_IDX),
        .GNT_VALID (GNT_VALID),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    function automatic int pickRef(logic [7:0] r, int p);
        for (int d = 1; d <= 8; d++) begin
            if (r[(p + d) % 8]) return (p + d) % 8;
        end
        return -1;
    endfunction

    task automatic modelReset();
        mValid = 0;
        mIdx   = 0;
        mPtr   = 7;
        mHeld  = 0;
        mTo    = 0;
    endtask

    task automatic modelEdge(logic en, logic [7:0] req);
        int w;
        bit still, hit;
        mTo = 0;
        w = pickRef(req, mPtr);
        if (mValid == 0) begin
            if (en && w >= 0) begin
                mValid = 1; mIdx = w; mPtr = w; mHeld = 1;
            end
        end else begin
            still = req[mIdx];
            hit = (MAXH != 0) && (mHeld >= MAXH);
            if (still && !hit) begin
                mHeld++;
            end else begin
                mTo = (still && hit) ? 1 : 0;
                if (en && w >= 0) begin
                    mIdx = w; mPtr = w; mHeld = 1;
                end else begin
                    mValid = 0;
                end
            end
        end
    endtask

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chkAll(string tag);
        logic [7:0] eg;
        logic [7:0] one;
        one = 8'h01;
        eg = (mValid != 0) ? (one << mIdx) : 8'h00;
        chk({tag, ".gnt"}, GNT, eg);
        chk({tag, ".idx"}, {5'd0, GNT_IDX}, 8'(mIdx));
        chk({tag, ".valid"}, {7'd0, GNT_VALID}, 8'(mValid));
        chk({tag, ".timeout"}, {7'd0, TIMEOUT}, 8'(mTo));
    endtask

    task automatic step(string tag, logic en, logic [7:0] req);
        EN  = en;
        REQ = req;
        @(posedge CLK);
        modelEdge(en, req);
        #1;
        chkAll(tag);
    endtask

    initial begin
        logic [7:0] r;
        modelReset();
        #1;
        chkAll("reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        step("t1.grant", 1'b1, 8'h08);
        chk("t1.gnt08", GNT, 8'h08);
        step("t1.drop", 1'b1, 8'h00);
        chk("t1.gnt00", GNT, 8'h00);

        for (int i = 0; i < 12; i++) begin
            r = 8'h81;
            if (mValid != 0 && mHeld >= 2) r[mIdx] = 1'b0;
            step("t2.alt", 1'b1, r);
        end

        step("t3.idle", 1'b1, 8'h00);
        for (int i = 0; i < 40; i++) step("t3.hold", 1'b1, 8'h24);

        step("t4.idle", 1'b1, 8'h00);
        for (int i = 0; i < 26; i++) begin
            step("t4.solo", 1'b1, 8'h10);
            chk("t4.valid", {7'd0, GNT_VALID}, 8'h01);
        end

        step("t5.idle", 1'b1, 8'h00);
        step("t5.g1", 1'b1, 8'h02);
        step("t5.g1b", 1'b1, 8'h02);
        step("t5.off", 1'b0, 8'h40);
        chk("t5.gnt00", GNT, 8'h00);
        step("t5.stay", 1'b0, 8'h40);
        step("t5.on", 1'b1, 8'h40);
        chk("t5.gnt40", GNT, 8'h40);

        step("t6.idle", 1'b1, 8'h00);
        step("t6.g5", 1'b1, 8'h20);
        step("t6.g5b", 1'b1, 8'h20);
        #2;
        RST_N = 1'b0;
        modelReset();
        #1;
        chkAll("t6.rst");
        @(negedge CLK);
        RST_N = 1'b1;
        step("t6.ff", 1'b1, 8'hFF);
        chk("t6.idx0", {5'd0, GNT_IDX}, 8'h00);

        for (int i = 0; i < 400; i++) begin
            r = 8'($urandom);
            if ($urandom_range(3) == 0) r = r & 8'($urandom);
            step("rand", ($urandom_range(7) != 0), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
Round-robin scheduler that shares one 8-way resource (ALU operand bus / result port) between 8 requesters.
- Holds the granted index as a 3-bit registered value.
- Drives the one-hot select through the team's 3-to-8 decoder.
- Enforces a per-grant hold limit so no requester starves the others.
- Sits between the requester front-ends and the ALU datapath select lines.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles one grant may last. Legal range 0..255; 0 means unlimited (hold until release).

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
EN  input  1  arbitration enable; 0 blocks new grants only
REQ  input  8  request vector, bit i = requester i
GNT  output  8  one-hot grant, all zero when GNT_VALID=0
GNT_IDX  output  3  binary index of current grant
GNT_VALID  output  1  a grant is active
TIMEOUT  output  1  one-cycle pulse when a grant is ended by MAX_HOLD

Behaviour:
- Reset values (asserted asynchronously on RST_N=0):
  - GNT=8'h00, GNT_IDX=3'd0, GNT_VALID=0, TIMEOUT=0.
  - State=IDLE, hold counter=0, priority pointer PTR=3'd7, so requester 0 has first priority.
- States: IDLE, GRANT.
- Winner selection (pick):
  - Search REQ starting at PTR+1 mod 8, ascending, wrapping at 7->0.
  - The first set bit wins.
  - The current/last grantee is therefore lowest priority.
- IDLE, cycle t: if EN=1 and REQ!=0, then at t+1:
  - State=GRANT, GNT_IDX=winner, GNT_VALID=1, PTR=winner, counter=0.
  - Latency REQ->GNT is exactly 1 cycle.
- GRANT, cycle t, release condition R = (REQ[GNT_IDX]==0) or (MAX_HOLD!=0 and counter==MAX_HOLD-1).
  - If R=0: keep the grant and increment the counter (8-bit, saturating at 255).
  - If R=1 and EN=1 and the pick over REQ (sampled at t) is non-empty: switch at t+1 to the new winner, counter=0, with no idle bubble.
    - On timeout, the current grantee is re-granted only if it is the sole requester; its counter restarts at 0.
  - If R=1 and (EN=0 or no requests): go to IDLE at t+1 with GNT=0, GNT_VALID=0. GNT_IDX keeps its last value.
- TIMEOUT:
  - High at t+1 iff the release at t was caused by the counter limit while REQ[GNT_IDX] was still 1.
  - Otherwise 0.
- EN=0 never revokes an active grant; it only suppresses new or next grants.
- GNT is combinational from the registered GNT_IDX and GNT_VALID; no glitch paths come from REQ.
- REQ changes on non-granted bits during GRANT have no effect until the next release.
- RST_N low mid-grant: all outputs return to reset values immediately; PTR returns to 7.
- MAX_HOLD=1: every grant lasts exactly 1 cycle, giving strict per-cycle rotation among active requesters.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1;
  - constants N_REQ=8, IDX_W=3, CNT_W=8.
- One sub-module is natural: DECODER3 instantiated with GNT_IDX[2:0] (bit 2 to input A, bit 1 to B, bit 0 to C). Its X[7:0] is ANDed with GNT_VALID to form GNT.
- Winner search stays inline as a rotate/priority-encode function.

Test Plan:
1. Reset then REQ=8'h08, EN=1 -> next cycle GNT=8'h08, GNT_IDX=3, GNT_VALID=1; drop REQ -> next cycle GNT=8'h00, GNT_VALID=0.
2. REQ=8'h81 held, each grantee drops its bit after 2 cycles then re-raises -> grants alternate idx 0 then 7 then 0 with no idle cycle between.
3. MAX_HOLD=8, REQ=8'h24 held constantly -> idx2 for 8 cycles, TIMEOUT pulse, idx5 for 8 cycles, TIMEOUT pulse, idx2 again.
4. REQ=8'h10 constant, MAX_HOLD=8 -> idx4 re-granted every 8 cycles, TIMEOUT pulses each period, GNT_VALID never drops.
5. During grant to idx1, set EN=0 and drop REQ[1] with REQ[6]=1 -> IDLE, GNT=0; set EN=1 -> GNT=8'h40 one cycle later.
6. Assert RST_N=0 mid-grant to idx5 -> GNT=0, GNT_VALID=0, GNT_IDX=0 immediately; after release with REQ=8'hFF -> first grant is idx0.
